// File: rtl/updown_counter_pkg.sv
// Shared constants and the per-edge decision type for updown_counter.
package updown_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        ST_CLR,
        ST_LOAD,
        ST_STEP,
        ST_HOLD
    } step_t;

    // clr beats load beats step; anything else holds.
    function automatic step_t decide(input logic clr, input logic load, input logic step_en);
        if (clr) begin
            return ST_CLR;
        end else if (load) begin
            return ST_LOAD;
        end else if (step_en) begin
            return ST_STEP;
        end
        return ST_HOLD;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enable cycles by PRESCALE; tick marks the enable cycle that completes a phase.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic enable,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q, phase_d;

    assign tick = enable & (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (enable) begin
            phase_d = tick ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with wrap or saturate boundaries, wrap pulse and sticky boundary flag.
// Optional enable prescaler built when UPDOWN_COUNTER_PRESCALE_EN is defined.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    step_t            decision;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // Load restarts the phase just like clear does.
    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr | load),
        .enable(enable),
        .tick  (tick)
    );
`else
    // PRESCALE has no effect in this build; the term is constant true.
    assign tick = enable & (PRESCALE != 0);
`endif

    assign decision = decide(clr, load, tick);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        unique case (decision)
            ST_CLR: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            ST_LOAD: begin
                count_d = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
            end
            ST_STEP: begin
                if (up_dn == DIR_UP) begin
                    if (count_q == MAX_COUNT) begin
                        ovf_d = 1'b1;
                        if (sat_mode == MODE_WRAP) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        ovf_d = 1'b1;
                        if (sat_mode == MODE_WRAP) begin
                            count_d = MAX_COUNT;
                            tc_d    = 1'b1;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: MAX_VAL=15 and MAX_VAL=10 instances share stimulus,
// plus a PRESCALE=4 instance when UPDOWN_COUNTER_PRESCALE_EN is defined.
module tb_updown_counter;
    import updown_counter_pkg::*;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int NDUT = 3;
    int mpre[3] = '{1, 1, 4};
`else
    localparam int NDUT = 2;
    int mpre[3] = '{1, 1, 1};
`endif
    int mmax[3] = '{15, 10, 15};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, load = 1'b0, enable = 1'b0, up_dn = 1'b0, sat_mode = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] c0, c1, c2;
    logic       t0, t1, t2, o0, o1, o2;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .count(c0), .tc(t0), .ovf(o0)
    );
    updown_counter #(.WIDTH(4), .MAX_VAL(10), .PRESCALE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .count(c1), .tc(t1), .ovf(o1)
    );
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    updown_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(4)) d2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .count(c2), .tc(t2), .ovf(o2)
    );
`else
    assign c2 = '0;
    assign t2 = 1'b0;
    assign o2 = 1'b0;
`endif

    typedef struct packed {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic       sat;
        logic [3:0] lv;
    } stim_t;
    typedef struct packed {
        logic [3:0] c;
        logic       t;
        logic       o;
    } obs_t;
    typedef obs_t [2:0] trio_t;

    trio_t sbq[$];
    int    checks = 0;
    int    failures = 0;
    int    mc[3], mp[3];
    logic  mt[3], mo[3];

    function automatic stim_t mk(input logic c, input logic l, input logic e, input logic u,
                                 input logic s, input int lv);
        stim_t r;
        r.clr = c; r.load = l; r.en = e; r.up = u; r.sat = s; r.lv = 4'(lv);
        return r;
    endfunction

    function automatic trio_t get_obs();
        trio_t r;
        r[0] = {c0, t0, o0};
        r[1] = {c1, t1, o1};
        r[2] = {c2, t2, o2};
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mc[k] = 0; mp[k] = 0; mt[k] = 1'b0; mo[k] = 1'b0;
        end
    endtask

    // Reference behaviour, written with signed integer overshoot detection.
    task automatic model_edge(input stim_t s);
        int nxt;
        for (int k = 0; k < 3; k++) begin
            mt[k] = 1'b0;
            if (s.clr) begin
                mc[k] = 0; mo[k] = 1'b0; mp[k] = 0;
            end else if (s.load) begin
                mc[k] = (int'(s.lv) > mmax[k]) ? mmax[k] : int'(s.lv);
                mp[k] = 0;
            end else if (s.en) begin
                if (mp[k] < mpre[k] - 1) begin
                    mp[k]++;
                end else begin
                    mp[k] = 0;
                    nxt = s.up ? mc[k] + 1 : mc[k] - 1;
                    if (nxt > mmax[k] || nxt < 0) begin
                        mo[k] = 1'b1;
                        if (!s.sat) begin
                            mc[k] = (nxt < 0) ? mmax[k] : 0;
                            mt[k] = 1'b1;
                        end
                    end else begin
                        mc[k] = nxt;
                    end
                end
            end
        end
    endtask

    task automatic drive(input stim_t s);
        trio_t e;
        clr = s.clr; load = s.load; enable = s.en; up_dn = s.up ? DIR_UP : DIR_DN;
        sat_mode = s.sat ? MODE_SAT : MODE_WRAP; load_val = s.lv;
        model_edge(s);
        for (int k = 0; k < 3; k++) e[k] = {4'(mc[k]), mt[k], mo[k]};
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        stim_t seq[$];
        trio_t e, o;
        #2;
        o = get_obs();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (o[k] !== '0) begin
                failures++;
                $display("FAIL reset_init dut%0d: got %b want 000000", k, o[k]);
            end
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        seq.push_back(mk(1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 7; i++) seq.push_back(mk(0, 0, 1, 1, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            e = sbq.pop_front(); o = get_obs();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (o[k] !== e[k]) begin
                    failures++;
                    $display("FAIL reset_count[%0d] dut%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                             i, k, o[k].c, o[k].t, o[k].o, e[k].c, e[k].t, e[k].o);
                end
            end
        end
        checks++;
        if (c0 !== 4'd7) begin
            failures++;
            $display("FAIL reset_precount: got %0d want 7", c0);
        end
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({c0, t0, o0} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async: got c=%0d tc=%b ovf=%b want c=0 tc=0 ovf=0", c0, t0, o0);
        end
        #2 rst_n = 1'b1;
        model_reset();
        drive(mk(0, 0, 1, 1, 0, 0));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = get_obs();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (o[k] !== e[k]) begin
                failures++;
                $display("FAIL reset_first_step dut%0d: got c=%0d want c=%0d", k, o[k].c, e[k].c);
            end
        end
    endtask

    task automatic test_wrap_up();
        stim_t seq[$];
        trio_t e, o;
        seq.push_back(mk(1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 16; i++) seq.push_back(mk(0, 0, 1, 1, 0, 0));
        seq.push_back(mk(0, 0, 0, 1, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            e = sbq.pop_front(); o = get_obs();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (o[k] !== e[k]) begin
                    failures++;
                    $display("FAIL wrap_up[%0d] dut%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                             i, k, o[k].c, o[k].t, o[k].o, e[k].c, e[k].t, e[k].o);
                end
            end
            if (i == 16) begin
                checks++;
                if ({c0, t0, o0} !== {4'd0, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL wrap_up_16th: got c=%0d tc=%b ovf=%b want c=0 tc=1 ovf=1",
                             c0, t0, o0);
                end
            end
        end
    endtask

    task automatic test_sat_down();
        stim_t seq[$];
        trio_t e, o;
        seq.push_back(mk(1, 0, 0, 0, 1, 0));
        seq.push_back(mk(0, 1, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++) seq.push_back(mk(0, 0, 1, 0, 1, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            e = sbq.pop_front(); o = get_obs();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (o[k] !== e[k]) begin
                    failures++;
                    $display("FAIL sat_down[%0d] dut%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                             i, k, o[k].c, o[k].t, o[k].o, e[k].c, e[k].t, e[k].o);
                end
            end
        end
        checks++;
        if ({c0, t0, o0} !== {4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sat_down_final: got c=%0d tc=%b ovf=%b want c=0 tc=0 ovf=1", c0, t0, o0);
        end
    endtask

    task automatic test_load();
        stim_t seq[$];
        trio_t e, o;
        logic [7:0] want[3] = '{{4'd9, 4'd9}, {4'd14, 4'd10}, {4'd0, 4'd0}};
        seq.push_back(mk(0, 1, 1, 1, 0, 9));
        seq.push_back(mk(0, 1, 1, 0, 0, 14));
        seq.push_back(mk(1, 1, 1, 1, 0, 5));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            e = sbq.pop_front(); o = get_obs();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (o[k] !== e[k]) begin
                    failures++;
                    $display("FAIL load[%0d] dut%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                             i, k, o[k].c, o[k].t, o[k].o, e[k].c, e[k].t, e[k].o);
                end
            end
            checks++;
            if ({c0, c1} !== want[i]) begin
                failures++;
                $display("FAIL load_value[%0d]: got %0d/%0d want %0d/%0d",
                         i, c0, c1, want[i][7:4], want[i][3:0]);
            end
        end
    endtask

    task automatic test_down_wrap();
        stim_t seq[$];
        trio_t e, o;
        seq.push_back(mk(1, 0, 0, 0, 0, 0));
        seq.push_back(mk(0, 0, 1, 0, 0, 0));
        seq.push_back(mk(0, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            e = sbq.pop_front(); o = get_obs();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (o[k] !== e[k]) begin
                    failures++;
                    $display("FAIL down_wrap[%0d] dut%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                             i, k, o[k].c, o[k].t, o[k].o, e[k].c, e[k].t, e[k].o);
                end
            end
            if (i == 1) begin
                checks++;
                if ({c1, t1, o1} !== {4'd10, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL down_wrap_max10: got c=%0d tc=%b ovf=%b want c=10 tc=1 ovf=1",
                             c1, t1, o1);
                end
            end
            if (i == 3) begin
                checks++;
                if (o1 !== 1'b0) begin
                    failures++;
                    $display("FAIL down_wrap_clr_ovf: got %b want 0", o1);
                end
            end
        end
    endtask

    task automatic test_random();
        trio_t e, o;
        stim_t s;
        for (int i = 0; i < 200; i++) begin
            s = mk(($urandom_range(15, 0) == 0), ($urandom_range(7, 0) == 0),
                   ($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)), int'($urandom_range(15, 0)));
            drive(s);
            @(posedge clk); #1;
            e = sbq.pop_front(); o = get_obs();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (o[k] !== e[k]) begin
                    failures++;
                    $display("FAIL random[%0d] dut%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                             i, k, o[k].c, o[k].t, o[k].o, e[k].c, e[k].t, e[k].o);
                end
            end
        end
    endtask

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    task automatic test_prescale();
        stim_t seq[$];
        trio_t e, o;
        seq.push_back(mk(1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 8; i++) seq.push_back(mk(0, 0, 1, 1, 0, 0));
        for (int i = 0; i < 2; i++) seq.push_back(mk(0, 0, 1, 1, 0, 0));
        seq.push_back(mk(0, 1, 1, 1, 0, 3));
        for (int i = 0; i < 4; i++) seq.push_back(mk(0, 0, 1, 1, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            @(posedge clk); #1;
            e = sbq.pop_front(); o = get_obs();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (o[k] !== e[k]) begin
                    failures++;
                    $display("FAIL prescale[%0d] dut%0d: got c=%0d tc=%b ovf=%b want c=%0d tc=%b ovf=%b",
                             i, k, o[k].c, o[k].t, o[k].o, e[k].c, e[k].t, e[k].o);
                end
            end
            if (i == 8) begin
                checks++;
                if ({c2, c0} !== {4'd2, 4'd8}) begin
                    failures++;
                    $display("FAIL prescale_8: got %0d/%0d want 2/8", c2, c0);
                end
            end
            if (i == 14 || i == 15) begin
                checks++;
                if (c2 !== ((i == 14) ? 4'd3 : 4'd4)) begin
                    failures++;
                    $display("FAIL prescale_reload[%0d]: got %0d want %0d", i, c2, (i == 14) ? 3 : 4);
                end
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load();
        test_down_wrap();
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
